// File: rtl/debug_scan_pkg.sv
// Shared types and constants for the debug scanner.
// The checksum word (see DEBUG_SCAN_CHECKSUM_EN in debug_scanner) uses CHK_ADDR.
package debug_scan_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStepHi,
        StStepLo,
        StSettle,
        StCapture,
        StSend,
        StDone
    } state_e;

    localparam int unsigned NUM_WORDS = 64;
    localparam logic [6:0]  CHK_ADDR  = 7'h7F;
    localparam logic [6:0]  LAST_ADDR = 7'(NUM_WORDS - 1);

endpackage

// File: rtl/debug_step_pulser.sv
// Generates one debug_step pulse: STEP_CYCLES high, then STEP_CYCLES low.
// pulse_done marks the final cycle of each phase so the caller can track high/low.
module debug_step_pulser #(
    parameter int unsigned STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    output logic debug_step,
    output logic pulse_done
);

    localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(STEP_CYCLES - 1);

    logic            active_q;
    logic            lo_q;
    logic [CntW-1:0] cnt_q;

    assign pulse_done = active_q && (cnt_q == CntLast);

    always_ff @(posedge clk) begin
        if (!rst) begin
            active_q   <= 1'b0;
            lo_q       <= 1'b0;
            cnt_q      <= '0;
            debug_step <= 1'b0;
        end else if (!active_q) begin
            if (trigger) begin
                active_q   <= 1'b1;
                lo_q       <= 1'b0;
                cnt_q      <= '0;
                debug_step <= 1'b1;
            end
        end else if (cnt_q == CntLast) begin
            cnt_q <= '0;
            if (!lo_q) begin
                lo_q       <= 1'b1;
                debug_step <= 1'b0;
            end else begin
                active_q <= 1'b0;
                lo_q     <= 1'b0;
            end
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/debug_scanner.sv
// Freezes the core, optionally single-steps it, then sweeps debug_addr 0..63 streaming each word.
// Define DEBUG_SCAN_CHECKSUM_EN to append an XOR checksum word at CHK_ADDR.
module debug_scanner
    import debug_scan_pkg::*;
#(
    parameter int unsigned STEP_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step_en,
    input  logic        halt,
    output logic        debug_en,
    output logic        debug_step,
    output logic [6:0]  debug_addr,
    input  logic [31:0] debug_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_addr,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

`ifdef DEBUG_SCAN_CHECKSUM_EN
    localparam bit ChkEn = 1'b1;
    logic [31:0] chk_q;
`else
    localparam bit ChkEn = 1'b0;
`endif

    localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e          state_q;
    logic [SetW-1:0] settle_cnt_q;
    logic            settle_done;
    logic            step_trigger;
    logic            pulse_done;

    // A zero settle count still spends one cycle in SETTLE.
    assign settle_done  = (SETTLE_CYCLES <= 1) || (settle_cnt_q == SetW'(SETTLE_CYCLES - 1));
    assign step_trigger = (state_q == StIdle) && start && step_en;
    assign busy         = (state_q != StIdle);
    assign debug_en     = halt | busy;

    debug_step_pulser #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_pulser (
        .clk        (clk),
        .rst        (rst),
        .trigger    (step_trigger),
        .debug_step (debug_step),
        .pulse_done (pulse_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            settle_cnt_q <= '0;
            debug_addr   <= '0;
            out_valid    <= 1'b0;
            out_addr     <= '0;
            out_data     <= '0;
            out_last     <= 1'b0;
            done         <= 1'b0;
`ifdef DEBUG_SCAN_CHECKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        debug_addr   <= '0;
                        settle_cnt_q <= '0;
                        state_q      <= step_en ? StStepHi : StSettle;
`ifdef DEBUG_SCAN_CHECKSUM_EN
                        chk_q        <= '0;
`endif
                    end
                end
                StStepHi: begin
                    if (pulse_done) state_q <= StStepLo;
                end
                StStepLo: begin
                    if (pulse_done) begin
                        debug_addr   <= '0;
                        settle_cnt_q <= '0;
                        state_q      <= StSettle;
                    end
                end
                StSettle: begin
                    if (settle_done) state_q <= StCapture;
                    else             settle_cnt_q <= settle_cnt_q + 1'b1;
                end
                StCapture: begin
                    out_data  <= debug_data;
                    out_addr  <= debug_addr;
                    out_valid <= 1'b1;
                    out_last  <= !ChkEn && (debug_addr == LAST_ADDR);
`ifdef DEBUG_SCAN_CHECKSUM_EN
                    chk_q     <= chk_q ^ debug_data;
`endif
                    state_q   <= StSend;
                end
                StSend: begin
                    if (out_ready) begin
`ifdef DEBUG_SCAN_CHECKSUM_EN
                        if (out_addr == CHK_ADDR) begin
                            out_valid  <= 1'b0;
                            debug_addr <= '0;
                            done       <= 1'b1;
                            state_q    <= StDone;
                        end else if (out_addr == LAST_ADDR) begin
                            // Checksum word follows back-to-back; out_valid stays high.
                            out_addr <= CHK_ADDR;
                            out_data <= chk_q;
                            out_last <= 1'b1;
                        end else begin
                            out_valid    <= 1'b0;
                            debug_addr   <= debug_addr + 7'd1;
                            settle_cnt_q <= '0;
                            state_q      <= StSettle;
                        end
`else
                        if (out_addr == LAST_ADDR) begin
                            out_valid  <= 1'b0;
                            debug_addr <= '0;
                            done       <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            out_valid    <= 1'b0;
                            debug_addr   <= debug_addr + 7'd1;
                            settle_cnt_q <= '0;
                            state_q      <= StSettle;
                        end
`endif
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_scanner.sv
// Directed bench for debug_scanner; define DEBUG_SCAN_CHECKSUM_EN to exercise the checksum build.
module tb_debug_scanner;

`ifdef DEBUG_SCAN_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int EXP_WORDS = CHK_EN ? 65 : 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        step_en;
    logic        halt;
    logic        debug_en;
    logic        debug_step;
    logic [6:0]  debug_addr;
    logic [31:0] debug_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        data_mode;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Core model: data is a pure function of the address.
    assign debug_data = data_mode ? (32'hFFFF0000 ^ 32'(debug_addr))
                                  : 32'(debug_addr) * 32'd3;

    debug_scanner dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step_en    (step_en),
        .halt       (halt),
        .debug_en   (debug_en),
        .debug_step (debug_step),
        .debug_addr (debug_addr),
        .debug_data (debug_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until done, counting transfers, done pulses and debug_step-high cycles.
    task automatic run_to_done(input int budget, output int words, output int dones,
                               output int steps, output bit timed_out);
        words = 0; dones = 0; steps = 0; timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (debug_step) steps++;
            if (out_valid && out_ready) words++;
            if (done) begin
                dones++;
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        if (!timed_out) begin
            for (int c = 0; c < 6; c++) begin
                tick();
                if (done) dones++;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] o;
        rst = 1'b0; start = 1'b0; step_en = 1'b0; halt = 1'b0; out_ready = 1'b0;
        data_mode = 1'b0;
        tick(); tick();
        o = {24'd0, debug_step, out_valid, out_last, busy, done, debug_en, 2'b00};
        checks++;
        if (o !== 32'd0) begin
            failures++;
            $display("FAIL reset_flags: got %h want 00000000", o);
        end
        checks++;
        if (debug_addr !== 7'd0 || out_addr !== 7'd0 || out_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_data: got daddr=%h oaddr=%h odata=%h want 0 0 0",
                     debug_addr, out_addr, out_data);
        end
        halt = 1'b1; #1;
        checks++;
        if (debug_en !== 1'b1) begin
            failures++;
            $display("FAIL halt_debug_en: got %b want 1", debug_en);
        end
        halt = 1'b0; #1;
        checks++;
        if (debug_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_debug_en: got %b want 0", debug_en);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_sweep();
        int idx = 0; int dones = 0; int steps = 0; bit fin = 1'b0;
        logic [31:0] exp_chk = '0;
        logic [6:0]  ea; logic [31:0] ed; logic el;
        data_mode = 1'b0; out_ready = 1'b1; step_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 1000 && !fin; c++) begin
            if (debug_step) steps++;
            if (out_valid && out_ready) begin
                if (idx < 64) begin
                    ea = 7'(idx); ed = 32'(idx * 3); exp_chk ^= ed; el = !CHK_EN && (idx == 63);
                end else begin
                    ea = 7'h7F; ed = exp_chk; el = 1'b1;
                end
                checks++;
                if (out_addr !== ea || out_data !== ed || out_last !== el) begin
                    failures++;
                    $display("FAIL sweep_word%0d: got addr=%h data=%h last=%b want addr=%h data=%h last=%b",
                             idx, out_addr, out_data, out_last, ea, ed, el);
                end
                idx++;
            end
            if (done) begin
                dones++;
                fin = 1'b1;
            end
            if (debug_en !== 1'b1) begin
                failures++;
                $display("FAIL sweep_debug_en: got %b want 1", debug_en);
            end
            tick();
        end
        checks++;
        if (!fin || idx != EXP_WORDS || dones != 1 || steps != 0) begin
            failures++;
            $display("FAIL sweep_totals: got words=%0d done=%0d step_cycles=%0d want %0d 1 0",
                     idx, dones, steps, EXP_WORDS);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || debug_addr !== 7'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL sweep_idle: got busy=%b done=%b daddr=%h valid=%b want 0 0 0 0",
                     busy, done, debug_addr, out_valid);
        end
    endtask

    task automatic test_step();
        int w; int d; int s; bit to;
        out_ready = 1'b1; step_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; step_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (debug_step !== (i < 4) || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL step_phase%0d: got step=%b valid=%b want step=%b valid=0",
                         i, debug_step, out_valid, (i < 4));
            end
            tick();
        end
        // Two cycles (settle + capture) before the first word appears.
        checks++;
        if (out_valid !== 1'b0 || debug_addr !== 7'd0) begin
            failures++;
            $display("FAIL step_settle: got valid=%b daddr=%h want 0 0", out_valid, debug_addr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL step_capture: got valid=%b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 7'd0 || out_data !== 32'd0) begin
            failures++;
            $display("FAIL step_first_word: got valid=%b addr=%h data=%h want 1 00 0",
                     out_valid, out_addr, out_data);
        end
        run_to_done(1000, w, d, s, to);
        checks++;
        if (to || w != EXP_WORDS || d != 1 || s != 0) begin
            failures++;
            $display("FAIL step_totals: got words=%0d done=%0d step_cycles=%0d want %0d 1 0",
                     w, d, s, EXP_WORDS);
        end
    endtask

    task automatic test_backpressure();
        int w; int d; int s; bit to; bit found = 1'b0;
        out_ready = 1'b1; step_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (out_valid && out_addr == 7'd5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL bp_reach_addr5: got found=0 want 1");
        end
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_addr !== 7'd5 || out_data !== 32'd15 ||
                debug_addr !== 7'd5) begin
                failures++;
                $display("FAIL bp_hold%0d: got valid=%b addr=%h data=%h daddr=%h want 1 05 f 05",
                         i, out_valid, out_addr, out_data, debug_addr);
            end
        end
        out_ready = 1'b1;
        run_to_done(1000, w, d, s, to);
        checks++;
        if (to || w != EXP_WORDS - 5 || d != 1) begin
            failures++;
            $display("FAIL bp_totals: got words=%0d done=%0d want %0d 1", w, d, EXP_WORDS - 5);
        end
    endtask

    task automatic test_ignore_start();
        int w; int d; int s; bit to; int w1 = 0; bit found = 1'b0;
        out_ready = 1'b1; step_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (out_valid && out_ready) w1++;
            if (debug_addr == 7'd20) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        start = 1'b1; step_en = 1'b1;
        tick();
        start = 1'b0; step_en = 1'b0;
        run_to_done(1000, w, d, s, to);
        checks++;
        if (!found || to || w1 + w != EXP_WORDS || d != 1 || s != 0) begin
            failures++;
            $display("FAIL ignore_start: got found=%b words=%0d done=%0d step_cycles=%0d want 1 %0d 1 0",
                     found, w1 + w, d, s, EXP_WORDS);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_step();
        int w; int d; int s; bit to;
        out_ready = 1'b1; step_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; step_en = 1'b0;
        tick();
        checks++;
        if (debug_step !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_step: got step=%b busy=%b want 1 1", debug_step, busy);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (debug_step !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 ||
            out_last !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_flags: got step=%b busy=%b done=%b valid=%b last=%b want all 0",
                     debug_step, busy, done, out_valid, out_last);
        end
        checks++;
        if (debug_addr !== 7'd0 || out_addr !== 7'd0 || out_data !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_data: got daddr=%h oaddr=%h odata=%h want 0 0 0",
                     debug_addr, out_addr, out_data);
        end
        rst = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || debug_addr !== 7'd0 || debug_step !== 1'b0) begin
            failures++;
            $display("FAIL rst_restart: got busy=%b daddr=%h step=%b want 1 00 0",
                     busy, debug_addr, debug_step);
        end
        run_to_done(1000, w, d, s, to);
        checks++;
        if (to || w != EXP_WORDS || d != 1 || s != 0) begin
            failures++;
            $display("FAIL rst_restart_totals: got words=%0d done=%0d step_cycles=%0d want %0d 1 0",
                     w, d, s, EXP_WORDS);
        end
    endtask

`ifdef DEBUG_SCAN_CHECKSUM_EN
    task automatic test_checksum();
        int idx = 0; bit fin = 1'b0;
        data_mode = 1'b1; out_ready = 1'b1; step_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 1000 && !fin; c++) begin
            if (out_valid && out_ready) begin
                if (idx == 63) begin
                    checks++;
                    if (out_addr !== 7'd63 || out_data !== 32'hFFFF003F || out_last !== 1'b0) begin
                        failures++;
                        $display("FAIL chk_word63: got addr=%h data=%h last=%b want 3f ffff003f 0",
                                 out_addr, out_data, out_last);
                    end
                end else if (idx == 64) begin
                    checks++;
                    if (out_addr !== 7'h7F || out_data !== 32'h0 || out_last !== 1'b1) begin
                        failures++;
                        $display("FAIL chk_word: got addr=%h data=%h last=%b want 7f 00000000 1",
                                 out_addr, out_data, out_last);
                    end
                end
                idx++;
            end
            if (done) fin = 1'b1;
            tick();
        end
        checks++;
        if (!fin || idx != 65) begin
            failures++;
            $display("FAIL chk_totals: got done_seen=%b words=%0d want 1 65", fin, idx);
        end
        data_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sweep();
        test_step();
        test_backpressure();
        test_ignore_start();
        test_reset_mid_step();
`ifdef DEBUG_SCAN_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
